// File: rtl/seg7_scan_mux.sv
// N-digit multiplexed 7-segment driver: prescaled scan, guard interval, blanking,
// blink, leading-zero suppression and registered active-low pin outputs.
`timescale 1ns/1ps
module seg7_scan_mux #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 1000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dot_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  lz_suppress,
  output logic [N_DIGITS-1:0]   ano,
  output logic [6:0]            leds,
  output logic                  dot
);

  localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = $clog2(N_DIGITS);
  localparam int FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PRE_W-1:0]  pre;
  logic [IDX_W-1:0]  idx;
  logic [FCNT_W-1:0] fcnt;
  logic              phase;

  logic slot_end, idx_last, fcnt_last, guard_on, blanked, upper_zero;
  logic [3:0]          cur_nib;
  logic [N_DIGITS-1:0] sel;
  logic [N_DIGITS-1:0] ano_d;
  logic [6:0]          leds_d;
  logic                dot_d;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h27;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  assign slot_end  = (pre == PRE_W'(SCAN_DIV - 1));
  assign idx_last  = (idx == IDX_W'(N_DIGITS - 1));
  assign fcnt_last = (fcnt == FCNT_W'(BLINK_DIV - 1));

  // A zero-length guard would otherwise be an always-false unsigned compare.
  if (GUARD > 0) begin : g_guard
    assign guard_on = (pre < PRE_W'(GUARD));
  end else begin : g_no_guard
    assign guard_on = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre   <= '0;
      idx   <= '0;
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (slot_end) begin
        pre <= '0;
        if (idx_last) begin
          idx <= '0;
          if (fcnt_last) begin
            fcnt  <= '0;
            phase <= ~phase;
          end else begin
            fcnt <= fcnt + FCNT_W'(1);
          end
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    cur_nib    = digits[4*idx +: 4];
    blanked    = blank_mask[idx] | (blink_mask[idx] & phase);
    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i >= int'(idx) && digits[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    sel      = '1;
    sel[idx] = 1'b0;
    ano_d    = '1;
    leds_d   = 7'h7F;
    dot_d    = 1'b1;
    if (guard_on || blanked) begin
      ano_d = '1;
    end else if (lz_suppress && idx != '0 && upper_zero) begin
      // Suppressed zero keeps its anode and decimal point; only segments go dark.
      ano_d = sel;
      dot_d = ~dot_in[idx];
    end else begin
      ano_d  = sel;
      leds_d = seg7(cur_nib);
      dot_d  = ~dot_in[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      ano  <= '1;
      leds <= 7'h7F;
      dot  <= 1'b1;
    end else begin
      ano  <= ano_d;
      leds <= leds_d;
      dot  <= dot_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: a spec-level model pushes expected pin values
// into a scoreboard queue each cycle; directed steps add fixed-value checks.
`timescale 1ns/1ps
module tb_seg7_scan_mux;

  localparam int N_DIGITS = 4, SCAN_DIV = 4, GUARD = 1, BLINK_DIV = 2;
  localparam logic [11:0] OFF = {4'hF, 7'h7F, 1'b1};

  logic        clk = 1'b0;
  logic        rst, en, lz_suppress;
  logic [15:0] digits;
  logic [3:0]  dot_in, blank_mask, blink_mask;
  logic [3:0]  ano;
  logic [6:0]  leds;
  logic        dot;

  seg7_scan_mux #(.N_DIGITS(N_DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dot_in(dot_in),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_suppress(lz_suppress),
    .ano(ano), .leds(leds), .dot(dot)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_pre = 0, m_idx = 0, m_fcnt = 0;
  bit m_phase = 1'b0;
  logic [11:0] sb_q[$];
  logic [11:0] hist[64];
  logic [11:0] last_obs;
  logic [6:0]  seg_tbl[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  function automatic logic [11:0] mk(logic [3:0] a, logic [6:0] l, logic d);
    return {a, l, d};
  endfunction

  function automatic logic [11:0] model_out();
    logic [15:0] upper;
    logic [3:0]  nib, anod;
    if (rst || !en) return OFF;
    if (m_pre < GUARD) return OFF;
    if (blank_mask[m_idx] || (blink_mask[m_idx] && m_phase)) return OFF;
    upper = digits >> (4 * m_idx);
    nib   = upper[3:0];
    anod  = 4'hF & ~(4'h1 << m_idx);
    if (lz_suppress && m_idx != 0 && upper == 16'h0) return {anod, 7'h7F, ~dot_in[m_idx]};
    return {anod, seg_tbl[nib], ~dot_in[m_idx]};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: push expectation, advance model at the edge, compare 1ns later.
  task automatic step(input string tag);
    logic [11:0] expv;
    sb_q.push_back(model_out());
    @(posedge clk);
    if (rst) begin
      m_pre = 0; m_idx = 0; m_fcnt = 0; m_phase = 1'b0;
    end else if (en) begin
      if (m_pre == SCAN_DIV - 1) begin
        m_pre = 0;
        if (m_idx == N_DIGITS - 1) begin
          m_idx = 0;
          if (m_fcnt == BLINK_DIV - 1) begin
            m_fcnt = 0; m_phase = ~m_phase;
          end else m_fcnt++;
        end else m_idx++;
      end else m_pre++;
    end
    #1;
    expv     = sb_q.pop_front();
    last_obs = {ano, leds, dot};
    check(tag, last_obs, expv);
    check({tag, "_onehot"}, {11'd0, ($countones(~ano) <= 1)}, 12'd1);
    @(negedge clk);
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      step(tag);
      if (k < 64) hist[k] = last_obs;
    end
  endtask

  // Slot starting at hist[base]: one guard cycle then three cycles of v.
  task automatic slot_check(input string tag, input int base, input logic [11:0] v);
    check({tag, "_guard"}, hist[base], OFF);
    for (int k = 1; k < 4; k++) check(tag, hist[base + k], v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] scan_v[4];
    rst = 1'b1; en = 1'b1; lz_suppress = 1'b0; digits = 16'h1234;
    dot_in = '0; blank_mask = '0; blink_mask = '0;
    @(negedge clk);

    // Reset held three cycles with enable high.
    for (int k = 0; k < 3; k++) begin
      step("reset");
      check("reset_off", last_obs, OFF);
    end

    // Scan order over two full periods.
    rst = 1'b0; digits = 16'h1A2F; dot_in = 4'b0100;
    scan_v = '{mk(4'hE, 7'h0E, 1), mk(4'hD, 7'h24, 1), mk(4'hB, 7'h08, 0), mk(4'h7, 7'h79, 1)};
    run(32, "scan");
    for (int k = 0; k < 32; k += 4) slot_check("scan_slot", k, scan_v[(k / 4) % 4]);

    // Leading-zero suppression.
    dot_in = '0; lz_suppress = 1'b1;
    rst = 1'b1; digits = 16'h0070; step("lz_rst"); rst = 1'b0;
    run(16, "lz0070");
    slot_check("lz0070_s0", 0, mk(4'hE, 7'h40, 1));
    slot_check("lz0070_s1", 4, mk(4'hD, 7'h78, 1));
    slot_check("lz0070_s2", 8, mk(4'hB, 7'h7F, 1));
    slot_check("lz0070_s3", 12, mk(4'h7, 7'h7F, 1));
    rst = 1'b1; digits = 16'h0000; step("lz_rst"); rst = 1'b0;
    run(16, "lz0000");
    slot_check("lz0000_s0", 0, mk(4'hE, 7'h40, 1));
    slot_check("lz0000_s1", 4, mk(4'hD, 7'h7F, 1));
    slot_check("lz0000_s3", 12, mk(4'h7, 7'h7F, 1));
    rst = 1'b1; digits = 16'h0700; step("lz_rst"); rst = 1'b0;
    run(16, "lz0700");
    slot_check("lz0700_s1", 4, mk(4'hD, 7'h40, 1));
    slot_check("lz0700_s2", 8, mk(4'hB, 7'h78, 1));
    slot_check("lz0700_s3", 12, mk(4'h7, 7'h7F, 1));

    // Blink on digit 0, permanent blank on digit 3, four frames.
    lz_suppress = 1'b0; digits = 16'h1A2F; dot_in = 4'b0100;
    blink_mask = 4'b0001; blank_mask = 4'b1000;
    rst = 1'b1; step("blink_rst"); rst = 1'b0;
    run(64, "blink");
    for (int f = 0; f < 4; f++) begin
      slot_check("blink_s0", f * 16, (f < 2) ? mk(4'hE, 7'h0E, 1) : OFF);
      slot_check("blink_s1", f * 16 + 4, mk(4'hD, 7'h24, 1));
      slot_check("blank_s3", f * 16 + 12, OFF);
    end

    // Enable dropped at idx=2, pre=2, held 10 cycles, then resumed.
    blink_mask = '0; blank_mask = '0;
    rst = 1'b1; step("en_rst"); rst = 1'b0;
    run(10, "en_pre");
    check("en_before", hist[9], mk(4'hB, 7'h08, 0));
    en = 1'b0;
    step("en_drop");
    check("en_off", last_obs, OFF);
    run(10, "en_hold");
    check("en_hold_off", hist[9], OFF);
    en = 1'b1;
    run(4, "en_resume");
    check("en_resume0", hist[0], mk(4'hB, 7'h08, 0));
    check("en_resume1", hist[1], mk(4'hB, 7'h08, 0));
    check("en_guard3", hist[2], OFF);
    check("en_digit3", hist[3], mk(4'h7, 7'h79, 1));

    // Reset at idx=3 with blink phase 1.
    blink_mask = 4'b0001;
    rst = 1'b1; step("mid_rst0"); rst = 1'b0;
    run(46, "mid_run");
    check("mid_phase1", hist[33], OFF);
    check("mid_idx3", hist[45], mk(4'h7, 7'h79, 1));
    rst = 1'b1;
    step("mid_rst");
    check("mid_rst_off", last_obs, OFF);
    rst = 1'b0;
    run(2, "mid_after");
    check("mid_after_guard", hist[0], OFF);
    check("mid_after_d0", hist[1], mk(4'hE, 7'h0E, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
